// File: rtl/alu_pkg.sv
// Shared constants for the ALU: default widths, control-bit indices and
// the fixed divide-by-zero quotient.
package alu_pkg;

    localparam int ALU_BITS      = 32;
    localparam int ALU_SIG_COUNT = 12;

    // Bit positions inside the one-hot control word
    localparam int ADD = 0;
    localparam int SUB = 1;
    localparam int MUL = 2;
    localparam int DIV = 3;
    localparam int SHR = 4;
    localparam int SHL = 5;
    localparam int ROR = 6;
    localparam int ROL = 7;
    localparam int AND = 8;
    localparam int OR  = 9;
    localparam int NEG = 10;
    localparam int NOT = 11;

    // Quotient reported when the divisor is zero
    localparam logic [ALU_BITS-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_if.sv
// Operand / control / result bundle between the datapath and the ALU.
interface alu_if
    import alu_pkg::*;
#(
    parameter int BITS      = ALU_BITS,
    parameter int SIG_COUNT = ALU_SIG_COUNT
);
    logic        [SIG_COUNT-1:0] ctrl_signal;
    logic signed [BITS-1:0]      X;
    logic signed [BITS-1:0]      Y;
    logic signed [BITS-1:0]      OpResult_HI;
    logic signed [BITS-1:0]      OpResult_LO;

    modport master (
        output ctrl_signal, X, Y,
        input  OpResult_HI, OpResult_LO
    );

    modport slave (
        input  ctrl_signal, X, Y,
        output OpResult_HI, OpResult_LO
    );
endinterface

// File: rtl/alu_divider.sv
// Signed combinational divider. Quotient truncates toward zero, remainder
// carries the sign of the dividend. A zero divisor yields an all-ones
// quotient and returns the dividend as remainder.
module alu_divider
    import alu_pkg::*;
#(
    parameter int BITS = ALU_BITS
) (
    input  logic signed [BITS-1:0] x,
    input  logic signed [BITS-1:0] y,
    output logic signed [BITS-1:0] quo,
    output logic signed [BITS-1:0] rem
);

    logic [BITS-1:0] ax;
    logic [BITS-1:0] ay;
    logic [BITS-1:0] q_mag;
    logic [BITS-1:0] r_mag;
    logic            y_zero;
    logic            neg_q;

    // Divide magnitudes unsigned (so the most negative value still has a
    // representable magnitude), then restore signs.
    always_comb begin
        ax     = x[BITS-1] ? -x : x;
        ay     = y[BITS-1] ? -y : y;
        y_zero = (y == '0);
        neg_q  = x[BITS-1] ^ y[BITS-1];
        q_mag  = '0;
        r_mag  = '0;
        if (!y_zero) begin
            q_mag = ax / ay;
            r_mag = ax % ay;
        end
        if (y_zero) begin
            quo = BITS'(DIV_BY_ZERO_Q);
            rem = x;
        end else begin
            quo = neg_q ? -q_mag : q_mag;
            rem = x[BITS-1] ? -r_mag : r_mag;
        end
    end

endmodule

// File: rtl/alu.sv
// Signed ALU: decodes a one-hot control word (lowest set bit wins),
// computes the selected operation combinationally and registers a HI/LO
// result pair one clock later.
module alu
    import alu_pkg::*;
#(
    parameter int BITS      = ALU_BITS,
    parameter int SIG_COUNT = ALU_SIG_COUNT
) (
    input logic  clk,
    input logic  clr,
    alu_if.slave bus
);

    localparam int SH_W = $clog2(BITS);

    logic signed [BITS-1:0]   x_p0;
    logic signed [BITS-1:0]   y_p0;
    logic [SH_W-1:0]          sh_p0;
    logic signed [2*BITS-1:0] prod_p0;
    logic [2*BITS-1:0]        ror_full_p0;
    logic [2*BITS-1:0]        rol_full_p0;
    logic signed [BITS-1:0]   quo_p0;
    logic signed [BITS-1:0]   rem_p0;
    logic                     any_p0;
    int                       sel_p0;
    logic signed [BITS-1:0]   hi_p0;
    logic signed [BITS-1:0]   lo_p0;
    logic signed [BITS-1:0]   hi_p1;
    logic signed [BITS-1:0]   lo_p1;

    assign x_p0  = bus.X;
    assign y_p0  = bus.Y;
    assign sh_p0 = bus.Y[SH_W-1:0];

    assign prod_p0 = $signed({{BITS{x_p0[BITS-1]}}, x_p0})
                   * $signed({{BITS{y_p0[BITS-1]}}, y_p0});

    // Rotates shift a doubled copy of X and pick the wrapped half
    assign ror_full_p0 = {x_p0, x_p0} >> sh_p0;
    assign rol_full_p0 = {x_p0, x_p0} << sh_p0;

    alu_divider #(.BITS(BITS)) u_divider (
        .x   (x_p0),
        .y   (y_p0),
        .quo (quo_p0),
        .rem (rem_p0)
    );

    // Priority decode: scanning downward leaves the lowest set index in sel
    always_comb begin
        any_p0 = 1'b0;
        sel_p0 = 0;
        for (int i = SIG_COUNT - 1; i >= 0; i--) begin
            if (bus.ctrl_signal[i]) begin
                any_p0 = 1'b1;
                sel_p0 = i;
            end
        end
    end

    // Result mux; HI stays zero except for mul and div
    always_comb begin
        hi_p0 = '0;
        lo_p0 = '0;
        if (any_p0) begin
            case (sel_p0)
                ADD: lo_p0 = x_p0 + y_p0;
                SUB: lo_p0 = x_p0 - y_p0;
                MUL: begin
                    hi_p0 = prod_p0[2*BITS-1:BITS];
                    lo_p0 = prod_p0[BITS-1:0];
                end
                DIV: begin
                    hi_p0 = rem_p0;
                    lo_p0 = quo_p0;
                end
                SHR: lo_p0 = $unsigned(x_p0) >> sh_p0;
                SHL: lo_p0 = x_p0 << sh_p0;
                ROR: lo_p0 = ror_full_p0[BITS-1:0];
                ROL: lo_p0 = rol_full_p0[2*BITS-1:BITS];
                AND: lo_p0 = x_p0 & y_p0;
                OR:  lo_p0 = x_p0 | y_p0;
                NEG: lo_p0 = -x_p0;
                NOT: lo_p0 = ~x_p0;
                default: begin
                    hi_p0 = '0;
                    lo_p0 = '0;
                end
            endcase
        end
    end

    // Output register; clr forces zero immediately and holds it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hi_p1 <= '0;
            lo_p1 <= '0;
        end else begin
            hi_p1 <= hi_p0;
            lo_p1 <= lo_p0;
        end
    end

    assign bus.OpResult_HI = hi_p1;
    assign bus.OpResult_LO = lo_p1;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the ALU: every operation, control-word priority,
// asynchronous clear and one-cycle latency.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic clr;
    int   tests;
    int   fails;

    localparam logic [31:0] M15 = 32'hFFFF_FFF1;
    localparam logic [31:0] M5  = 32'hFFFF_FFFB;
    localparam logic [31:0] M2  = 32'hFFFF_FFFE;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] oh(input int b);
        logic [11:0] one;
        one = 12'd1;
        return one << b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y);
        bus.ctrl_signal = c;
        bus.X           = x;
        bus.Y           = y;
    endtask

    task automatic run(input string tag, input logic [11:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(c, x, y);
        @(posedge clk);
        #1;
        check({tag, "_hi"}, bus.OpResult_HI, exp_hi);
        check({tag, "_lo"}, bus.OpResult_LO, exp_lo);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr   = 1'b1;
        drive(oh(ADD), 32'd15, 32'd5);
        #2;
        check("reset_hi", bus.OpResult_HI, 32'd0);
        check("reset_lo", bus.OpResult_LO, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held_lo", bus.OpResult_LO, 32'd0);
        clr = 1'b0;
        #2;
        check("post_release_before_edge", bus.OpResult_LO, 32'd0);
        @(posedge clk);
        #1;
        check("first_capture", bus.OpResult_LO, 32'd20);

        run("add_pp", oh(ADD), 32'd15, 32'd5, 32'd0, 32'd20);
        run("add_np", oh(ADD), M15,    32'd5, 32'd0, 32'hFFFF_FFF6);
        run("add_pn", oh(ADD), 32'd15, M5,    32'd0, 32'd10);
        run("add_nn", oh(ADD), M15,    M5,    32'd0, 32'hFFFF_FFEC);

        run("sub_pp", oh(SUB), 32'd15, 32'd5, 32'd0, 32'd10);
        run("sub_np", oh(SUB), M15,    32'd5, 32'd0, 32'hFFFF_FFEC);
        run("sub_pn", oh(SUB), 32'd15, M5,    32'd0, 32'd20);
        run("sub_nn", oh(SUB), M15,    M5,    32'd0, 32'hFFFF_FFF6);

        run("mul_pp", oh(MUL), 32'd15, 32'd5, 32'd0, 32'd75);
        run("mul_np", oh(MUL), M15,    32'd5, ONES,  32'hFFFF_FFB5);
        run("mul_pn", oh(MUL), 32'd15, M5,    ONES,  32'hFFFF_FFB5);
        run("mul_nn", oh(MUL), M15,    M5,    32'd0, 32'd75);

        run("div_pp", oh(DIV), 32'd15, 32'd5, 32'd0, 32'd3);
        run("div_np", oh(DIV), M15,    32'd5, 32'd0, 32'hFFFF_FFFD);
        run("div_pn", oh(DIV), 32'd15, M5,    32'd0, 32'hFFFF_FFFD);
        run("div_nn", oh(DIV), M15,    M5,    32'd0, 32'd3);
        run("div_7_m2", oh(DIV), 32'd7, M2,   32'd1, 32'hFFFF_FFFD);
        run("div_m7_2", oh(DIV), 32'hFFFF_FFF9, 32'd2, ONES, 32'hFFFF_FFFD);
        run("div_by_0", oh(DIV), 32'd5, 32'd0, 32'd5, ONES);

        run("shr", oh(SHR), 32'd16, 32'd2, 32'd0, 32'd4);
        run("shl", oh(SHL), 32'd16, 32'd2, 32'd0, 32'd64);
        run("ror", oh(ROR), 32'd16, 32'd2, 32'd0, 32'd4);
        run("rol", oh(ROL), 32'd16, 32'd2, 32'd0, 32'd64);
        run("rol_wrap", oh(ROL), 32'h8000_0001, 32'd1, 32'd0, 32'h0000_0003);
        run("ror_wrap", oh(ROR), 32'h8000_0001, 32'd1, 32'd0, 32'hC000_0000);
        run("shr_y33", oh(SHR), 32'h8000_0000, 32'd33, 32'd0, 32'h4000_0000);

        run("and", oh(AND), 32'd15, 32'd0, 32'd0, 32'd0);
        run("or",  oh(OR),  32'd15, 32'd0, 32'd0, 32'd15);
        run("and_mix", oh(AND), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'h00F0_000F);
        run("neg", oh(NEG), 32'd15, 32'd0, 32'd0, 32'hFFFF_FFF1);
        run("not", oh(NOT), 32'd15, 32'd0, 32'd0, 32'hFFFF_FFF0);

        run("mul_before_none", oh(MUL), M15, 32'd5, ONES, 32'hFFFF_FFB5);
        run("ctrl_zero", 12'd0, 32'd15, 32'd5, 32'd0, 32'd0);
        run("ctrl_multi", 12'b0000_0000_0011, 32'd15, 32'd5, 32'd0, 32'd20);
        run("ctrl_multi_hi", 12'b1100_0000_1100, 32'd15, 32'd5, 32'd0, 32'd75);

        // Latency: new inputs must not show until the next edge
        drive(oh(SUB), 32'd15, 32'd5);
        #2;
        check("latency_old_lo", bus.OpResult_LO, 32'd75);
        @(posedge clk);
        #1;
        check("latency_new_lo", bus.OpResult_LO, 32'd10);

        // Asynchronous clear between edges
        drive(oh(MUL), M15, 32'd5);
        @(posedge clk);
        #1;
        check("pre_clr_hi", bus.OpResult_HI, ONES);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_hi", bus.OpResult_HI, 32'd0);
        check("clr_async_lo", bus.OpResult_LO, 32'd0);
        @(posedge clk);
        #1;
        check("clr_hold_lo", bus.OpResult_LO, 32'd0);
        clr = 1'b0;
        drive(oh(NOT), 32'd15, 32'd0);
        #2;
        check("clr_release_lo", bus.OpResult_LO, 32'd0);
        @(posedge clk);
        #1;
        check("after_clr_capture", bus.OpResult_LO, 32'hFFFF_FFF0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
